// File: rtl/ping_initiator.sv
// Initiator for a single-wire level request/acknowledge link: issues requests,
// times them out, measures acknowledge latency and keeps saturating statistics.
module ping_initiator #(
    parameter int TimeoutCycles = 16,
    parameter int GapCycles     = 4,
    parameter int CntWidth      = 8,
    localparam int LatWidth     = $clog2(TimeoutCycles + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    output logic                signal_one_o,
    input  logic                signal_two_i,
    output logic                busy_o,
    output logic [CntWidth-1:0] ok_cnt_o,
    output logic [CntWidth-1:0] to_cnt_o,
    output logic [LatWidth-1:0] last_lat_o,
    output logic                err_o
);

    // One shared sequence counter covers both the WAIT and the GAP phase.
    localparam int MAX_CYCLES = (TimeoutCycles > GapCycles) ? TimeoutCycles : GapCycles;
    localparam int SEQ_WIDTH  = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [SEQ_WIDTH-1:0] SEQ_ZERO     = SEQ_WIDTH'(1'b0);
    localparam logic [SEQ_WIDTH-1:0] SEQ_ONE      = SEQ_WIDTH'(1'b1);
    localparam logic [SEQ_WIDTH-1:0] TIMEOUT_LAST = SEQ_WIDTH'(TimeoutCycles - 1);
    localparam logic [SEQ_WIDTH-1:0] GAP_LAST     = SEQ_WIDTH'(GapCycles - 1);
    localparam logic [CntWidth-1:0]  CNT_ONE      = CntWidth'(1'b1);
    localparam logic [CntWidth-1:0]  CNT_MAX      = {CntWidth{1'b1}};
    localparam logic [LatWidth-1:0]  LAT_ONE      = LatWidth'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [SEQ_WIDTH-1:0] seq_r;
    logic [SEQ_WIDTH-1:0] seq_next_s;
    logic                 run_r;
    logic                 run_next_s;
    logic                 ok_inc_s;
    logic                 to_inc_s;
    logic                 lat_load_s;
    logic                 err_set_s;
    logic [LatWidth-1:0]  lat_next_s;

    // Next-state, sequence counter and statistic-update decode.
    always_comb begin
        state_next_s = state_r;
        seq_next_s   = seq_r;
        run_next_s   = run_r;
        ok_inc_s     = 1'b0;
        to_inc_s     = 1'b0;
        lat_load_s   = 1'b0;
        err_set_s    = 1'b0;
        // Latency is cnt+1 so an acknowledge in the first WAIT cycle reads 1.
        lat_next_s   = LatWidth'({1'b0, seq_r}) + LAT_ONE;

        case (state_r)
            ST_IDLE: begin
                err_set_s = signal_two_i;
                if (start_i) begin
                    run_next_s   = ~stop_i;
                    state_next_s = ST_WAIT;
                    seq_next_s   = SEQ_ZERO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                seq_next_s = seq_r + SEQ_ONE;
                if (stop_i) begin
                    run_next_s = 1'b0;
                end else begin
                    run_next_s = run_r;
                end
                // Acknowledge wins over timeout in the same cycle.
                if (signal_two_i) begin
                    ok_inc_s     = 1'b1;
                    lat_load_s   = 1'b1;
                    state_next_s = ST_GAP;
                    seq_next_s   = SEQ_ZERO;
                end else if (seq_r == TIMEOUT_LAST) begin
                    to_inc_s     = 1'b1;
                    err_set_s    = 1'b1;
                    state_next_s = ST_GAP;
                    seq_next_s   = SEQ_ZERO;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                seq_next_s = seq_r + SEQ_ONE;
                if (stop_i) begin
                    run_next_s = 1'b0;
                end else begin
                    run_next_s = run_r;
                end
                // The first GAP cycle may still carry the tail of a legal acknowledge.
                err_set_s = signal_two_i & (seq_r != SEQ_ZERO);
                if (seq_r == GAP_LAST) begin
                    seq_next_s = SEQ_ZERO;
                    if (run_next_s) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                seq_next_s   = SEQ_ZERO;
                run_next_s   = 1'b0;
            end
        endcase
    end

    // State, sequence counter, registered outputs and saturating statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            seq_r        <= SEQ_ZERO;
            run_r        <= 1'b0;
            signal_one_o <= 1'b0;
            busy_o       <= 1'b0;
            ok_cnt_o     <= {CntWidth{1'b0}};
            to_cnt_o     <= {CntWidth{1'b0}};
            last_lat_o   <= {LatWidth{1'b0}};
            err_o        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            seq_r        <= seq_next_s;
            run_r        <= run_next_s;
            signal_one_o <= (state_next_s == ST_WAIT);
            busy_o       <= (state_next_s != ST_IDLE);
            if (ok_inc_s && (ok_cnt_o != CNT_MAX)) begin
                ok_cnt_o <= ok_cnt_o + CNT_ONE;
            end
            if (to_inc_s && (to_cnt_o != CNT_MAX)) begin
                to_cnt_o <= to_cnt_o + CNT_ONE;
            end
            if (lat_load_s) begin
                last_lat_o <= lat_next_s;
            end
            if (err_set_s) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ping_initiator.sv
// Scoreboard bench for ping_initiator: each busy episode (from start to the
// return to IDLE) is compared against a hand-computed expectation.
module tb_ping_initiator;

    logic       clk;
    logic       rst;
    logic       start_a, stop_a;
    logic       sig1_a, sig2_a, busy_a, err_a;
    logic [7:0] ok_a, to_a;
    logic [4:0] lat_a;

    logic       start_b, stop_b, resp_b_en;
    logic       sig1_b, sig2_b, busy_b, err_b;
    logic [1:0] ok_b, to_b;
    logic [4:0] lat_b;

    // Responder model for DUT A.
    logic       resp_en, tail_en, resp_s2, spur;
    int         ack_delay;
    int         hi_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]      ok;
        logic [7:0]      to;
        logic [7:0]      lat;
        logic            err;
        logic [3:0]      nruns;
        logic [3:0][7:0] runs;
    } exp_t;

    exp_t exp_q[$];

    ping_initiator dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .stop_i(stop_a),
        .signal_one_o(sig1_a), .signal_two_i(sig2_a), .busy_o(busy_a),
        .ok_cnt_o(ok_a), .to_cnt_o(to_a), .last_lat_o(lat_a), .err_o(err_a)
    );

    ping_initiator #(.CntWidth(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .stop_i(stop_b),
        .signal_one_o(sig1_b), .signal_two_i(sig2_b), .busy_o(busy_b),
        .ok_cnt_o(ok_b), .to_cnt_o(to_b), .last_lat_o(lat_b), .err_o(err_b)
    );

    assign sig2_a = resp_s2 | spur;
    assign sig2_b = sig1_b & resp_b_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int ok, input int to, input int lat, input int err,
                                input int n, input int r0, input int r1,
                                input int r2, input int r3);
        exp_t e;
        e.ok      = 8'(ok);
        e.to      = 8'(to);
        e.lat     = 8'(lat);
        e.err     = 1'(err);
        e.nruns   = 4'(n);
        e.runs[0] = 8'(r0);
        e.runs[1] = 8'(r1);
        e.runs[2] = 8'(r2);
        e.runs[3] = 8'(r3);
        return e;
    endfunction

    // Responder: acknowledges in the ack_delay-th request cycle, optionally
    // holding the level one extra cycle into GAP.
    initial begin
        resp_s2 = 1'b0;
        hi_cnt  = 0;
        forever begin
            @(negedge clk);
            if (sig1_a === 1'b1) begin
                hi_cnt++;
                resp_s2 = resp_en && (hi_cnt == ack_delay);
            end else begin
                resp_s2 = resp_en && tail_en && (hi_cnt != 0) && (hi_cnt == ack_delay);
                hi_cnt  = 0;
            end
        end
    end

    // Monitor: records signal_one run lengths during a busy episode and
    // compares the whole episode when busy drops.
    initial begin
        logic            prev_busy;
        logic            cur_lvl;
        int              run_len;
        int              got_n;
        logic [3:0][7:0] got_runs;
        exp_t            e;
        prev_busy = 1'b0;
        cur_lvl   = 1'b0;
        run_len   = 0;
        got_n     = 0;
        got_runs  = '0;
        forever begin
            @(negedge clk);
            if (busy_a === 1'b1) begin
                if (run_len != 0 && sig1_a == cur_lvl) begin
                    run_len++;
                end else begin
                    if (run_len != 0) begin
                        if (got_n < 4) got_runs[got_n] = 8'(run_len);
                        got_n++;
                    end
                    cur_lvl = sig1_a;
                    run_len = 1;
                end
            end else if (prev_busy) begin
                if (got_n < 4) got_runs[got_n] = 8'(run_len);
                got_n++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_episode", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ok_cnt", int'(ok_a), int'(e.ok));
                    chk("to_cnt", int'(to_a), int'(e.to));
                    chk("last_lat", int'(lat_a), int'(e.lat));
                    chk("err", int'(err_a), int'(e.err));
                    chk("sig1_idle", int'(sig1_a), 0);
                    chk("nruns", got_n, int'(e.nruns));
                    for (int i = 0; i < 4; i++) begin
                        if (i < int'(e.nruns)) chk($sformatf("run%0d", i), int'(got_runs[i]), int'(e.runs[i]));
                    end
                end
                got_n   = 0;
                run_len = 0;
            end
            prev_busy = (busy_a === 1'b1);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic with_stop);
        start_a = 1'b1;
        stop_a  = with_stop;
        @(negedge clk);
        start_a = 1'b0;
        stop_a  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0;
        resp_en = 1'b0; tail_en = 1'b0; spur = 1'b0; ack_delay = 0; resp_b_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_sig1", int'(sig1_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_ok", int'(ok_a), 0);
        chk("reset_to", int'(to_a), 0);
        chk("reset_lat", int'(lat_a), 0);
        chk("reset_err", int'(err_a), 0);

        // Continuous run, ack in 3rd request cycle, stop during the 2nd WAIT.
        resp_en = 1'b1; ack_delay = 3;
        exp_q.push_back(mk(2, 0, 3, 0, 4, 3, 4, 3, 4));
        pulse_start(1'b0);
        repeat (8) @(negedge clk);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        drain("drain_two_acks");
        chk("busy_after_two_acks", int'(busy_a), 0);

        // Single shot, silent responder: full timeout.
        do_reset();
        resp_en = 1'b0;
        exp_q.push_back(mk(0, 1, 0, 1, 2, 16, 4, 0, 0));
        pulse_start(1'b1);
        drain("drain_timeout");

        // Ack in the last legal cycle, level held into first GAP cycle.
        do_reset();
        resp_en = 1'b1; tail_en = 1'b1; ack_delay = 16;
        exp_q.push_back(mk(1, 0, 16, 0, 2, 16, 4, 0, 0));
        pulse_start(1'b1);
        drain("drain_edge_ack");
        tail_en = 1'b0;

        // Spurious acknowledge while idle.
        do_reset();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("idle_spur_err", int'(err_a), 1);
        chk("idle_spur_ok", int'(ok_a), 0);
        chk("idle_spur_to", int'(to_a), 0);
        chk("idle_spur_busy", int'(busy_a), 0);

        // Spurious acknowledge in GAP cycle 3 of a single shot.
        do_reset();
        resp_en = 1'b1; ack_delay = 2;
        exp_q.push_back(mk(1, 0, 2, 1, 2, 2, 4, 0, 0));
        pulse_start(1'b1);
        repeat (4) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        drain("drain_gap_spur");

        // Narrow counters: six immediate-ack exchanges saturate at 3.
        do_reset();
        resp_b_en = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (25) @(negedge clk);
        stop_b = 1'b1;
        @(negedge clk);
        stop_b = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy_b === 1'b0) break;
            @(negedge clk);
        end
        chk("sat_idle", int'(busy_b), 0);
        chk("sat_ok", int'(ok_b), 3);
        chk("sat_to", int'(to_b), 0);
        chk("sat_lat", int'(lat_b), 1);
        chk("sat_err", int'(err_b), 0);

        // Reset in WAIT cycle 5, then a fresh single shot.
        do_reset();
        resp_en = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 0));
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sig1", int'(sig1_a), 0);
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_to", int'(to_a), 0);
        chk("midrst_err", int'(err_a), 0);
        rst = 1'b0;
        @(negedge clk);
        drain("drain_midrst");
        resp_en = 1'b1; ack_delay = 2;
        exp_q.push_back(mk(1, 0, 2, 0, 2, 2, 4, 0, 0));
        pulse_start(1'b1);
        drain("drain_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
